// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared constants, FSM encoding and immediate-pairing rule for the fetch unit.
package instr_fetch_unit_pkg;
    localparam int DEF_ADDR_W   = 20;
    localparam int DEF_RESET_PC = 0;
    localparam int DEF_DEPTH    = 2;
    localparam int IMM_FLAG_BIT = 2;

    typedef enum logic [1:0] {
        S_RESET_WAIT = 2'd0,
        S_RUN        = 2'd1,
        S_STALL      = 2'd2,
        S_FLUSH      = 2'd3
    } fetch_state_t;

    // An opcode with the flag bit set is followed by exactly one immediate halfword.
    function automatic logic next_expect_imm(input logic expect_imm, input logic [15:0] word);
        return !expect_imm && word[IMM_FLAG_BIT];
    endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory read port plus tagged halfword stream towards decode.
interface instr_fetch_unit_if import instr_fetch_unit_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_word;
    logic              out_is_imm;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output imem_en, imem_addr, out_valid, out_word, out_is_imm, out_pc,
        input  imem_rdata, out_ready
    );
    modport slave (
        input  imem_en, imem_addr, out_valid, out_word, out_is_imm, out_pc,
        output imem_rdata, out_ready
    );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// instr_fetch_unit_fifo: small synchronous FIFO with registered head, flush and occupancy count.
module instr_fetch_unit_fifo import instr_fetch_unit_pkg::*; #(
    parameter type entry_t = logic [15:0],
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  entry_t        i_data,
    input  logic          i_pop,
    input  logic          i_clear,
    output logic          o_valid,
    output entry_t        o_head,
    output logic [CW-1:0] o_count
);
    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_mem[r_wr] <= i_data;
            r_wr    <= r_wr + AW'(i_push);
            r_rd    <= r_rd + AW'(i_pop);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_valid = r_count != '0;
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    // The issue throttle upstream must keep pushes away from a full buffer.
    assert property (@(posedge clk) disable iff (!rst_n) !(i_push && !i_clear && r_count == CW'(DEPTH)));
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencer issuing one halfword read per cycle into a tagged output FIFO,
// with epoch-based dropping of stale returns on branch/interrupt redirect.
module instr_fetch_unit import instr_fetch_unit_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_fetch_halt,
    instr_fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [15:0]       word;
        logic              is_imm;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    fetch_state_t      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, r_tag_addr;
    logic              r_inflight, r_tag_epoch, r_epoch, r_expect_imm;
    logic [CW-1:0]     w_count, w_occ;
    logic              w_pop, w_push, w_issue, w_head_valid;
    entry_t            w_in, w_head;

    // Occupancy the FIFO will have once this cycle's pop and pending return settle.
    assign w_pop   = w_head_valid && bus.out_ready;
    assign w_occ   = w_count - CW'(w_pop) + CW'(r_inflight);
    assign w_issue = !i_fetch_halt && !i_redirect_valid && r_state != S_RESET_WAIT && w_occ < CW'(DEPTH);
    assign w_push  = r_inflight && r_tag_epoch == r_epoch && !i_redirect_valid;
    assign w_in    = '{word: bus.imem_rdata, is_imm: r_expect_imm, pc: r_tag_addr};

    assign bus.imem_en    = w_issue;
    assign bus.imem_addr  = r_pc;
    assign bus.out_valid  = w_head_valid;
    assign bus.out_word   = w_head.word;
    assign bus.out_is_imm = w_head.is_imm;
    assign bus.out_pc     = w_head.pc;

    always_comb begin
        w_state_nxt = S_RUN;
        if (i_redirect_valid) w_state_nxt = S_FLUSH;
        else if ((r_state == S_RUN || r_state == S_STALL) && !w_issue) w_state_nxt = S_STALL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RESET_WAIT;
            r_pc         <= RESET_PC;
            r_inflight   <= 1'b0;
            r_tag_epoch  <= 1'b0;
            r_tag_addr   <= '0;
            r_epoch      <= 1'b0;
            r_expect_imm <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag_epoch <= r_epoch;
                r_tag_addr  <= r_pc;
            end
            if (i_redirect_valid) begin
                r_pc         <= i_redirect_pc;
                r_epoch      <= ~r_epoch;
                r_expect_imm <= 1'b0;
            end else begin
                if (w_issue) r_pc <= r_pc + ADDR_W'(1);
                if (w_push) r_expect_imm <= next_expect_imm(r_expect_imm, bus.imem_rdata);
            end
        end
    end

    instr_fetch_unit_fifo #(.entry_t(entry_t), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_push),
        .i_data (w_in),
        .i_pop  (w_pop),
        .i_clear(i_redirect_valid),
        .o_valid(w_head_valid),
        .o_head (w_head),
        .o_count(w_count)
    );
endmodule
